// File: rtl/mmio_periph_responder.sv
// Peripheral responder on the CPU data-memory bus: timer, LED, 7-seg, UART-TX and status registers.
// Optional free-running SYSTICK counter at offset 0x14 is built when PERIPH_SYSTICK_EN is defined.
module mmio_periph_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int          BAUD_DIV  = 434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        IRQ,
  output logic [7:0]  leds,
  output logic [11:0] digits,
  output logic        uart_tx,
  output logic [1:0]  uart_state_o
);

  localparam logic [2:0] OFS_TH   = 3'd0;
  localparam logic [2:0] OFS_TL   = 3'd1;
  localparam logic [2:0] OFS_TCON = 3'd2;
  localparam logic [2:0] OFS_LED  = 3'd3;
  localparam logic [2:0] OFS_DIG  = 3'd4;
  localparam logic [2:0] OFS_TICK = 3'd5;
  localparam logic [2:0] OFS_UTXD = 3'd6;
  localparam logic [2:0] OFS_UCON = 3'd7;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam int            CW        = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

  logic          hit, rd_en, wr_en, busy;
  logic [2:0]    sel;
  logic [31:0]   rd_mux, systick_val;

  logic [31:0]   th_q, th_d, tl_q, tl_d, rdata_q;
  logic [2:0]    tcon_q, tcon_d;
  logic [7:0]    leds_q, leds_d;
  logic [11:0]   digits_q, digits_d;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;

  assign hit   = (Address[31:5] == BASE_ADDR[31:5]);
  assign sel   = Address[4:2];
  assign rd_en = hit & MemRead;
  assign wr_en = hit & MemWrite;
  assign busy  = (state_q != S_IDLE);

`ifdef PERIPH_SYSTICK_EN
  logic [31:0] systick_q;
  always_ff @(posedge clk) begin
    if (reset) systick_q <= 32'h0;
    else       systick_q <= systick_q + 32'd1;
  end
  assign systick_val = systick_q;
`else
  assign systick_val = 32'h0;
`endif

  always_comb begin
    rd_mux = 32'h0;
    case (sel)
      OFS_TH:   rd_mux = th_q;
      OFS_TL:   rd_mux = tl_q;
      OFS_TCON: rd_mux = {29'h0, tcon_q};
      OFS_LED:  rd_mux = {24'h0, leds_q};
      OFS_DIG:  rd_mux = {20'h0, digits_q};
      OFS_TICK: rd_mux = systick_val;
      OFS_UCON: rd_mux = {31'h0, busy};
      default:  rd_mux = 32'h0;
    endcase
  end

  // A CPU write to TL or TCON suppresses that cycle's increment, reload and status set.
  always_comb begin
    th_d     = th_q;
    tl_d     = tl_q;
    tcon_d   = tcon_q;
    leds_d   = leds_q;
    digits_d = digits_q;
    if (wr_en && sel == OFS_TH)  th_d     = WriteData;
    if (wr_en && sel == OFS_LED) leds_d   = WriteData[7:0];
    if (wr_en && sel == OFS_DIG) digits_d = WriteData[11:0];
    if (wr_en && sel == OFS_TL) begin
      tl_d = WriteData;
    end else if (wr_en && sel == OFS_TCON) begin
      tcon_d = WriteData[2:0];
    end else if (tcon_q[0]) begin
      if (&tl_q) begin
        tl_d = th_q;
        if (tcon_q[1]) tcon_d[2] = 1'b1;
      end else begin
        tl_d = tl_q + 32'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    if (state_q == S_IDLE) begin
      if (wr_en && sel == OFS_UTXD) begin
        shift_d = WriteData[7:0];
        cnt_d   = BAUD_LAST;
        bit_d   = 3'd0;
        state_d = S_START;
      end
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end else begin
      cnt_d = BAUD_LAST;
      case (state_q)
        S_START: state_d = S_DATA;
        S_DATA: begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      th_q     <= 32'h0;
      tl_q     <= 32'h0;
      tcon_q   <= 3'h0;
      leds_q   <= 8'h0;
      digits_q <= 12'h0;
      rdata_q  <= 32'h0;
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= 3'd0;
      shift_q  <= 8'h0;
    end else begin
      th_q     <= th_d;
      tl_q     <= tl_d;
      tcon_q   <= tcon_d;
      leds_q   <= leds_d;
      digits_q <= digits_d;
      rdata_q  <= rd_en ? rd_mux : 32'h0;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
    end
  end

  always_comb begin
    case (state_q)
      S_START: uart_tx = 1'b0;
      S_DATA:  uart_tx = shift_q[0];
      default: uart_tx = 1'b1;
    endcase
  end

  assign ReadData     = rdata_q;
  assign IRQ          = tcon_q[1] & tcon_q[2];
  assign leds         = leds_q;
  assign digits       = digits_q;
  assign uart_state_o = state_q;

endmodule

// File: tb/tb_mmio_periph_responder.sv
// Bench for mmio_periph_responder: directed scenarios plus random bus traffic, scored against
// a cycle-indexed behavioural model of the register map, timer and UART frame timing.
module tb_mmio_periph_responder;
  localparam int          B    = 4;
  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam int          W    = 54;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] Address = 32'h0;
  logic [31:0] WriteData = 32'h0;
  logic [31:0] ReadData;
  logic        IRQ;
  logic [7:0]  leds;
  logic [11:0] digits;
  logic        uart_tx;
  logic [1:0]  uart_state;

  always #5 clk = ~clk;

  mmio_periph_responder #(.BASE_ADDR(BASE), .BAUD_DIV(B)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .Address(Address), .WriteData(WriteData), .ReadData(ReadData), .IRQ(IRQ),
    .leds(leds), .digits(digits), .uart_tx(uart_tx), .uart_state_o(uart_state)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, expv, $time);
    end
  endtask

  // Reference model state; the UART is modelled as a frame start time plus the latched byte.
  logic [31:0] m_th, m_tl, m_systick;
  logic [2:0]  m_tcon;
  logic [7:0]  m_leds, m_byte;
  logic [11:0] m_dig;
  logic        m_active = 1'b0;
  int          m_start = 0;
  int          m_edge = 0;

  function automatic logic m_busy_at(input int e);
    return m_active && (e - m_start) < 10 * B;
  endfunction

  function automatic logic m_tx_at(input int e);
    int k;
    if (!m_busy_at(e)) return 1'b1;
    k = (e - m_start) / B;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_byte[k-1];
    return 1'b1;
  endfunction

  task automatic model_step(input logic rst, input logic rd, input logic wr,
                            input logic [31:0] addr, input logic [31:0] wd);
    logic        hit;
    int          ofs;
    logic [31:0] rdv;
    logic [31:0] old_th;
    logic        pre_busy;
    m_edge++;
    hit      = (addr >= BASE) && ((addr - BASE) < 32'd32);
    ofs      = int'((addr - BASE) >> 2);
    pre_busy = m_busy_at(m_edge - 1);
    rdv      = 32'h0;
    if (rst) begin
      m_th = 0; m_tl = 0; m_tcon = 0; m_leds = 0; m_dig = 0; m_systick = 0;
      m_active = 1'b0;
    end else begin
      if (hit && rd) begin
        case (ofs)
          0: rdv = m_th;
          1: rdv = m_tl;
          2: rdv = {29'h0, m_tcon};
          3: rdv = {24'h0, m_leds};
          4: rdv = {20'h0, m_dig};
`ifdef PERIPH_SYSTICK_EN
          5: rdv = m_systick;
`endif
          7: rdv = {31'h0, pre_busy};
          default: rdv = 32'h0;
        endcase
      end
      m_systick = m_systick + 1;
      old_th = m_th;
      if (hit && wr && ofs == 1) m_tl = wd;
      else if (hit && wr && ofs == 2) m_tcon = wd[2:0];
      else if (m_tcon[0]) begin
        if (m_tl == 32'hFFFF_FFFF) begin
          m_tl = old_th;
          if (m_tcon[1]) m_tcon[2] = 1'b1;
        end else m_tl = m_tl + 1;
      end
      if (hit && wr && ofs == 0) m_th = wd;
      if (hit && wr && ofs == 3) m_leds = wd[7:0];
      if (hit && wr && ofs == 4) m_dig = wd[11:0];
      if (hit && wr && ofs == 6 && !pre_busy) begin
        m_active = 1'b1;
        m_start  = m_edge;
        m_byte   = wd[7:0];
      end
    end
    exp_q.push_back({m_tx_at(m_edge), m_tcon[1] & m_tcon[2], m_leds, m_dig, rdv});
  endtask

  // Driver: one bus cycle per call, inputs applied on the falling edge.
  task automatic cycle(input logic rst, input logic rd, input logic wr,
                       input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clk);
    reset = rst; MemRead = rd; MemWrite = wr; Address = addr; WriteData = wd;
    model_step(rst, rd, wr, addr, wd);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic wr_reg(input int ofs, input logic [31:0] d);
    cycle(1'b0, 1'b0, 1'b1, BASE + 32'(ofs * 4), d);
  endtask

  task automatic rd_chk(input string name, input logic [31:0] addr, input logic [31:0] expv);
    cycle(1'b0, 1'b1, 1'b0, addr, 32'h0);
    @(posedge clk); #2;
    check(name, ReadData, expv);
  endtask

  task automatic sample_after_edge();
    @(posedge clk); #2;
  endtask

  // Monitor: every DUT clock edge that follows a modelled cycle is scored.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("sb_rdata",  ReadData, mon_e[31:0]);
      check("sb_digits", {20'h0, digits}, {20'h0, mon_e[43:32]});
      check("sb_leds",   {24'h0, leds}, {24'h0, mon_e[51:44]});
      check("sb_irq",    {31'h0, IRQ}, {31'h0, mon_e[52]});
      check("sb_uart_tx", {31'h0, uart_tx}, {31'h0, mon_e[53]});
    end
  end

  logic [9:0]  frame;
  logic [31:0] r_addr, r_wd;
  int          r_sel;

  initial begin
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    sample_after_edge();
    check("rst_uart_tx", {31'h0, uart_tx}, 32'h1);
    check("rst_irq", {31'h0, IRQ}, 32'h0);
    for (int i = 0; i < 8; i++) begin
      if (i != 5) rd_chk("rst_read", BASE + 32'(i * 4), 32'h0);
      else cycle(1'b0, 1'b1, 1'b0, BASE + 32'h14, 32'h0);
    end

    // Timer overflow with reload and sticky status
    wr_reg(0, 32'hFFFF_FFF0);
    wr_reg(1, 32'hFFFF_FFFE);
    wr_reg(2, 32'h3);
    idle(2);
    rd_chk("tcon_after_ovf", BASE + 32'h8, 32'h7);
    check("irq_set", {31'h0, IRQ}, 32'h1);
    rd_chk("tl_reloaded", BASE + 32'h4, 32'hFFFF_FFF1);
    wr_reg(2, 32'h3);
    sample_after_edge();
    check("irq_cleared", {31'h0, IRQ}, 32'h0);
    wr_reg(2, 32'h0);

    // CPU write to TL in the overflow cycle wins
    wr_reg(1, 32'hFFFF_FFFE);
    wr_reg(2, 32'h3);
    idle(1);
    wr_reg(1, 32'h5);
    rd_chk("tl_collision", BASE + 32'h4, 32'h5);
    rd_chk("tcon_collision", BASE + 32'h8, 32'h3);
    wr_reg(2, 32'h0);

    // UART frame for 0xA5 with an ignored mid-frame write
    frame = {1'b1, 8'hA5, 1'b0};
    wr_reg(6, 32'hA5);
    for (int i = 1; i <= 41; i++) begin
      if (i == 5 || i == 41) cycle(1'b0, 1'b1, 1'b0, BASE + 32'h1C, 32'h0);
      else if (i == 10) wr_reg(6, 32'hFF);
      else idle(1);
      sample_after_edge();
      if (i % B == 2 && i < 10 * B) check("uart_bit", {31'h0, uart_tx}, {31'h0, frame[i / B]});
      if (i == 5)  check("ucon_busy", ReadData, 32'h1);
      if (i == 41) check("ucon_done", ReadData, 32'h0);
    end

    // Reset in the DATA state aborts the frame
    wr_reg(6, 32'h3C);
    idle(10);
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    sample_after_edge();
    check("uart_tx_after_reset", {31'h0, uart_tx}, 32'h1);
    rd_chk("ucon_after_reset", BASE + 32'h1C, 32'h0);

    // Window edges, write-only reads, truncation and read-during-write
    rd_chk("outside_window", BASE + 32'h20, 32'h0);
    rd_chk("utxd_reads_zero", BASE + 32'h18, 32'h0);
    wr_reg(3, 32'h1FF);
    rd_chk("led_trunc", BASE + 32'hC, 32'hFF);
    check("leds_port", {24'h0, leds}, 32'hFF);
    wr_reg(4, 32'hFFFF_FABC);
    rd_chk("dig_trunc", BASE + 32'h10, 32'hABC);
    cycle(1'b0, 1'b1, 1'b1, BASE + 32'hC, 32'h55);
    sample_after_edge();
    check("rw_same_reg_old", ReadData, 32'hFF);
    rd_chk("rw_same_reg_new", BASE + 32'hC, 32'h55);

    // Random traffic scored only by the scoreboard
    for (int n = 0; n < 3000; n++) begin
      r_sel = $urandom_range(0, 9);
      if (r_sel == 0)      r_addr = $urandom();
      else if (r_sel == 1) r_addr = BASE + 32'h20 + 32'($urandom_range(0, 31));
      else                 r_addr = BASE + 32'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) r_wd = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else                           r_wd = $urandom();
      cycle($urandom_range(0, 299) == 0, $urandom_range(0, 9) < 4,
            $urandom_range(0, 9) < 4, r_addr, r_wd);
    end

    repeat (2) @(posedge clk);
    #3;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
